// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, slave channel FSM states and
// the write-request capture record.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} slv_wstate_t;
  typedef enum logic {R_IDLE, R_DATA} slv_rstate_t;

  // AW and W land independently, so the fields fill in separately
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } slv_wreq_t;

endpackage

// File: rtl/axi4_lite_regfile.sv
// Register storage for the AXI4-Lite slave: byte-strobed write port,
// asynchronous read port and a flat export of every register.
// AXIL_SLV_ID_REG_EN makes the top register a read-only ID constant.
module axi4_lite_regfile #(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001,
  localparam int         IDXW     = $clog2(NUM_REGS)
) (
  input  logic                     aclk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [IDXW-1:0]          wr_idx,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic [IDXW-1:0]          rd_idx,
  output logic [31:0]              rd_data,
  output logic                     wr_ro,
  output logic [NUM_REGS*32-1:0]   reg_out
);
  import axi4_lite_pkg::*;

`ifdef AXIL_SLV_ID_REG_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
  localparam logic [31:0] unused_id_value = ID_VALUE;
`endif

  localparam logic [IDXW-1:0] LAST = IDXW'(NUM_REGS - 1);

  logic [NUM_REGS-1:0][31:0] regs_q;

  // Write-protect flag for the index being written; lets the top pick SLVERR
  assign wr_ro = ID_EN && (wr_idx == LAST);

  // Byte-lane gated register update
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) regs_q[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rd_data = (ID_EN && (rd_idx == LAST)) ? ID_VALUE : regs_q[rd_idx];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_out[32*i +: 32] = (ID_EN && (i == NUM_REGS - 1)) ? ID_VALUE : regs_q[i];
  end

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave: independent write and read channel FSMs in front of a
// NUM_REGS x 32-bit register bank. All channel outputs are registered.
// Optional read-only ID register at the top index: AXIL_SLV_ID_REG_EN.
module axi4_lite_slave #(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic                   aclk,
  input  logic                   rst_n,
  input  logic [31:0]            awaddr,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [31:0]            araddr,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [31:0]            rdata,
  output logic [1:0]             rresp,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [NUM_REGS*32-1:0] reg_out
);
  import axi4_lite_pkg::*;

  localparam int          IDXW = $clog2(NUM_REGS);
  localparam logic [31:0] SPAN = 32'(NUM_REGS * 4);

  slv_wstate_t wstate_q, wstate_n;
  slv_rstate_t rstate_q, rstate_n;
  slv_wreq_t   wreq_q, wreq_n;
  logic        aw_got_q, aw_got_n, w_got_q, w_got_n;
  logic        awready_q, awready_n, wready_q, wready_n;
  logic        bvalid_q, bvalid_n, rvalid_q, rvalid_n, arready_q, arready_n;
  logic [1:0]  bresp_q, bresp_n, rresp_q, rresp_n;
  logic [31:0] rdata_q, rdata_n;
  logic        aw_hs, w_hs, wr_ok;

  logic            rf_we, rf_wro;
  logic [IDXW-1:0] rf_widx, rf_ridx;
  logic [31:0]     rf_rdata;

  axi4_lite_regfile #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE)) u_rf (
    .aclk    (aclk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .wr_idx  (rf_widx),
    .wdata   (wreq_n.data),
    .wstrb   (wreq_n.strb),
    .rd_idx  (rf_ridx),
    .rd_data (rf_rdata),
    .wr_ro   (rf_wro),
    .reg_out (reg_out)
  );

  // Merge this cycle's AW/W beats with whatever was captured earlier, so a
  // same-cycle completion sees the live bus values
  always_comb begin
    aw_hs  = awvalid && awready_q;
    w_hs   = wvalid && wready_q;
    wreq_n = wreq_q;
    if (aw_hs) wreq_n.addr = awaddr;
    if (w_hs) begin
      wreq_n.data = wdata;
      wreq_n.strb = wstrb;
    end
  end

  assign rf_widx = wreq_n.addr[2 +: IDXW];
  assign rf_ridx = araddr[2 +: IDXW];

  // Write FSM: collect AW and W in any order, commit, then hold B until taken
  always_comb begin
    wstate_n  = wstate_q;
    awready_n = awready_q;
    wready_n  = wready_q;
    bvalid_n  = bvalid_q;
    bresp_n   = bresp_q;
    aw_got_n  = aw_got_q;
    w_got_n   = w_got_q;
    rf_we     = 1'b0;
    wr_ok     = (wreq_n.addr < SPAN) && !rf_wro;
    case (wstate_q)
      W_IDLE: begin
        aw_got_n = aw_got_q || aw_hs;
        w_got_n  = w_got_q || w_hs;
        if (aw_got_n && w_got_n) begin
          rf_we     = wr_ok;
          bresp_n   = wr_ok ? RESP_OKAY : RESP_SLVERR;
          bvalid_n  = 1'b1;
          awready_n = 1'b0;
          wready_n  = 1'b0;
          aw_got_n  = 1'b0;
          w_got_n   = 1'b0;
          wstate_n  = W_RESP;
        end else begin
          awready_n = !aw_got_n;
          wready_n  = !w_got_n;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
          wstate_n  = W_IDLE;
        end
      end
      default: wstate_n = W_IDLE;
    endcase
  end

  // Write channel state; readys come up on the first edge out of reset
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q  <= W_IDLE;
      wreq_q    <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wstate_q  <= wstate_n;
      wreq_q    <= wreq_n;
      aw_got_q  <= aw_got_n;
      w_got_q   <= w_got_n;
      awready_q <= awready_n;
      wready_q  <= wready_n;
      bvalid_q  <= bvalid_n;
      bresp_q   <= bresp_n;
    end
  end

  // Read FSM: sample the bank on the AR handshake, hold R until taken.
  // Sampling pre-edge storage gives old data on a colliding write commit.
  always_comb begin
    rstate_n  = rstate_q;
    arready_n = arready_q;
    rvalid_n  = rvalid_q;
    rresp_n   = rresp_q;
    rdata_n   = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        arready_n = 1'b1;
        if (arvalid && arready_q) begin
          rdata_n   = (araddr < SPAN) ? rf_rdata : '0;
          rresp_n   = (araddr < SPAN) ? RESP_OKAY : RESP_SLVERR;
          rvalid_n  = 1'b1;
          arready_n = 1'b0;
          rstate_n  = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
          rstate_n  = R_IDLE;
        end
      end
      default: rstate_n = R_IDLE;
    endcase
  end

  // Read channel state
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      rstate_q  <= rstate_n;
      arready_q <= arready_n;
      rvalid_q  <= rvalid_n;
      rresp_q   <= rresp_n;
      rdata_q   <= rdata_n;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Directed bench for axi4_lite_slave (NUM_REGS=16). Inputs change 1 ns after
// the rising edge; outputs are sampled at the same point.
module tb_axi4_lite_slave;

  localparam int          NR     = 16;
  localparam logic [31:0] ID_VAL = 32'hA11E_0001;

  logic              aclk, rst_n;
  logic [31:0]       awaddr, wdata, araddr, rdata;
  logic [3:0]        wstrb;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [1:0]        bresp, rresp;
  logic [NR*32-1:0]  reg_out, exp_out;

  int tests = 0;
  int fails = 0;

  axi4_lite_slave #(.NUM_REGS(NR), .ID_VALUE(ID_VAL)) dut (
    .aclk(aclk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_out(reg_out)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [NR*32-1:0] reset_image();
    logic [NR*32-1:0] v;
    v = '0;
`ifdef AXIL_SLV_ID_REG_EN
    v[32*(NR-1) +: 32] = ID_VAL;
`endif
    return v;
  endfunction

  // Drive AW and W together; returns 1 ns after the edge completing both
  task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_f, w_f;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; awvalid || wvalid; n++) begin
      if (n >= 50) begin
        tests++; fails++;
        $display("FAIL write_timeout: addr %h never accepted", a);
        awvalid = 1'b0; wvalid = 1'b0;
        break;
      end
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      @(posedge aclk); #1;
      if (aw_f) awvalid = 1'b0;
      if (w_f)  wvalid  = 1'b0;
    end
  endtask

  task automatic finish_write();
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic start_read(input logic [31:0] a);
    logic ar_f;
    araddr = a; arvalid = 1'b1;
    for (int n = 0; arvalid; n++) begin
      if (n >= 50) begin
        tests++; fails++;
        $display("FAIL read_timeout: addr %h never accepted", a);
        arvalid = 1'b0;
        break;
      end
      ar_f = arready;
      @(posedge aclk); #1;
      if (ar_f) arvalid = 1'b0;
    end
  endtask

  task automatic finish_read();
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    exp_out = reset_image();
    repeat (3) @(posedge aclk);
    #1;
    tests++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      fails++; $display("FAIL reset_hs: got %b expected 00000", {awready, wready, arready, bvalid, rvalid});
    end
    tests++;
    if ({rdata, bresp, rresp} !== 36'h0) begin
      fails++; $display("FAIL reset_data: got rdata %h bresp %b rresp %b expected zeros", rdata, bresp, rresp);
    end
    tests++;
    if (reg_out !== exp_out) begin
      fails++; $display("FAIL reset_regs: got %h expected %h", reg_out, exp_out);
    end
    rst_n = 1'b1;
    tests++;
    if ({awready, wready, arready} !== 3'b000) begin
      fails++; $display("FAIL ready_before_edge: got %b expected 000", {awready, wready, arready});
    end
    @(posedge aclk); #1;
    tests++;
    if ({awready, wready, arready} !== 3'b111) begin
      fails++; $display("FAIL ready_after_edge: got %b expected 111", {awready, wready, arready});
    end
  endtask

  task automatic test_same_cycle();
    start_write(32'h08, 32'hCAFE_BABE, 4'hF);
    exp_out[95:64] = 32'hCAFE_BABE;
    tests++;
    if ({bvalid, bresp} !== 3'b100) begin
      fails++; $display("FAIL aw_w_same_b: got bvalid %b bresp %b expected 1 00", bvalid, bresp);
    end
    tests++;
    if (reg_out[95:64] !== 32'hCAFE_BABE) begin
      fails++; $display("FAIL aw_w_same_regout: got %h expected cafebabe", reg_out[95:64]);
    end
    finish_write();
    tests++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      fails++; $display("FAIL b_release: got %b expected 011", {bvalid, awready, wready});
    end
    start_read(32'h08);
    tests++;
    if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'hCAFE_BABE}) begin
      fails++; $display("FAIL read_08: got rvalid %b rresp %b rdata %h expected 1 00 cafebabe", rvalid, rresp, rdata);
    end
    finish_read();
    tests++;
    if ({rvalid, arready} !== 2'b01) begin
      fails++; $display("FAIL r_release: got %b expected 01", {rvalid, arready});
    end
  endtask

  task automatic test_w_first();
    start_write(32'h04, 32'hFFFF_FFFF, 4'hF);
    finish_write();
    awaddr = 32'h04; wdata = 32'h1122_3344; wstrb = 4'h5; wvalid = 1'b1;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({bvalid, wready, awready} !== 3'b001) begin
        fails++; $display("FAIL w_first_wait%0d: got %b expected 001", i, {bvalid, wready, awready});
      end
      if (i < 2) begin
        @(posedge aclk); #1;
      end
    end
    awvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    exp_out[63:32] = 32'hFF22_FF44;
    tests++;
    if ({bvalid, bresp} !== 3'b100) begin
      fails++; $display("FAIL w_first_b: got bvalid %b bresp %b expected 1 00", bvalid, bresp);
    end
    finish_write();
    start_read(32'h04);
    tests++;
    if (rdata !== 32'hFF22_FF44) begin
      fails++; $display("FAIL strobe_merge: got %h expected ff22ff44", rdata);
    end
    finish_read();
  endtask

  task automatic test_out_of_range();
    start_write(32'h40, 32'hDEAD_BEEF, 4'hF);
    tests++;
    if ({bvalid, bresp} !== 3'b110) begin
      fails++; $display("FAIL oor_write_b: got bvalid %b bresp %b expected 1 10", bvalid, bresp);
    end
    finish_write();
    tests++;
    if (reg_out !== exp_out) begin
      fails++; $display("FAIL oor_write_regs: got %h expected %h", reg_out, exp_out);
    end
    start_read(32'h40);
    tests++;
    if ({rresp, rdata} !== {2'b10, 32'h0}) begin
      fails++; $display("FAIL oor_read: got rresp %b rdata %h expected 10 00000000", rresp, rdata);
    end
    finish_read();
    start_write(32'h08, 32'h0000_0000, 4'h0);
    tests++;
    if ({bvalid, bresp} !== 3'b100) begin
      fails++; $display("FAIL strb0_b: got bvalid %b bresp %b expected 1 00", bvalid, bresp);
    end
    finish_write();
    tests++;
    if (reg_out !== exp_out) begin
      fails++; $display("FAIL strb0_regs: got %h expected %h", reg_out, exp_out);
    end
  endtask

  task automatic test_backpressure();
    start_write(32'h10, 32'h5555_0000, 4'hF);
    exp_out[159:128] = 32'h5555_0000;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({bvalid, bresp, awready, wready} !== 5'b1_00_0_0) begin
        fails++; $display("FAIL b_hold%0d: got %b expected 10000", i, {bvalid, bresp, awready, wready});
      end
      @(posedge aclk); #1;
    end
    finish_write();
    tests++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      fails++; $display("FAIL b_hold_release: got %b expected 011", {bvalid, awready, wready});
    end
    start_read(32'h10);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({rvalid, rresp, arready, rdata} !== {1'b1, 2'b00, 1'b0, 32'h5555_0000}) begin
        fails++; $display("FAIL r_hold%0d: got rvalid %b rresp %b arready %b rdata %h expected 1 00 0 55550000",
                          i, rvalid, rresp, arready, rdata);
      end
      @(posedge aclk); #1;
    end
    finish_read();
    tests++;
    if ({rvalid, arready} !== 2'b01) begin
      fails++; $display("FAIL r_hold_release: got %b expected 01", {rvalid, arready});
    end
  endtask

  task automatic test_same_edge();
    awaddr = 32'h0C; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; araddr = 32'h0C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    exp_out[127:96] = 32'hA5A5_A5A5;
    tests++;
    if ({bvalid, rvalid, rdata} !== {1'b1, 1'b1, 32'h0}) begin
      fails++; $display("FAIL collide_old: got bvalid %b rvalid %b rdata %h expected 1 1 00000000", bvalid, rvalid, rdata);
    end
    bready = 1'b1; rready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0; rready = 1'b0;
    start_read(32'h0C);
    tests++;
    if (rdata !== 32'hA5A5_A5A5) begin
      fails++; $display("FAIL collide_new: got %h expected a5a5a5a5", rdata);
    end
    finish_read();
  endtask

  task automatic test_top_reg();
    start_write(32'h3C, 32'h1234_5678, 4'hF);
`ifdef AXIL_SLV_ID_REG_EN
    tests++;
    if (bresp !== 2'b10) begin
      fails++; $display("FAIL id_write_resp: got %b expected 10", bresp);
    end
    finish_write();
    start_read(32'h3C);
    tests++;
    if ({rresp, rdata} !== {2'b00, ID_VAL}) begin
      fails++; $display("FAIL id_read: got rresp %b rdata %h expected 00 a11e0001", rresp, rdata);
    end
    finish_read();
`else
    exp_out[511:480] = 32'h1234_5678;
    tests++;
    if (bresp !== 2'b00) begin
      fails++; $display("FAIL top_write_resp: got %b expected 00", bresp);
    end
    finish_write();
    start_read(32'h3C);
    tests++;
    if ({rresp, rdata} !== {2'b00, 32'h1234_5678}) begin
      fails++; $display("FAIL top_read: got rresp %b rdata %h expected 00 12345678", rresp, rdata);
    end
    finish_read();
`endif
    tests++;
    if (reg_out !== exp_out) begin
      fails++; $display("FAIL top_regout: got %h expected %h", reg_out, exp_out);
    end
  endtask

  task automatic test_reset_mid();
    start_write(32'h00, 32'hDEAD_BEEF, 4'hF);
    start_read(32'h08);
    #2;
    rst_n = 1'b0;
    #1;
    exp_out = reset_image();
    tests++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b0) begin
      fails++; $display("FAIL mid_reset_hs: got %b expected 00000", {bvalid, rvalid, awready, wready, arready});
    end
    tests++;
    if (reg_out !== exp_out) begin
      fails++; $display("FAIL mid_reset_regs: got %h expected %h", reg_out, exp_out);
    end
    @(posedge aclk); #1;
    rst_n = 1'b1;
    @(posedge aclk); #1;
    tests++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      fails++; $display("FAIL mid_reset_release: got %b expected 11100", {awready, wready, arready, bvalid, rvalid});
    end
    start_read(32'h08);
    tests++;
    if ({rresp, rdata} !== {2'b00, 32'h0}) begin
      fails++; $display("FAIL mid_reset_cleared: got rresp %b rdata %h expected 00 00000000", rresp, rdata);
    end
    finish_read();
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_first();
    test_out_of_range();
    test_backpressure();
    test_same_edge();
    test_top_reg();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
